// File: rtl/sm_pkg.sv
// Shared encodings for the instruction sequencer: opcodes, ALU ops, states,
// decoded instruction kinds and the registered control-output bundle.
package sm_pkg;

    localparam int unsigned IDX_W = 3;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG
    } state_e;

    typedef enum logic [2:0] {
        INS_MOV_IMM,
        INS_MOV_REG,
        INS_ADD,
        INS_CMP,
        INS_AND,
        INS_MVN,
        INS_ILLEGAL
    } instr_e;

    typedef struct packed {
        logic             w;
        logic             err;
        logic [IDX_W-1:0] readnum;
        logic [IDX_W-1:0] writenum;
        logic             write;
        logic             loada;
        logic             loadb;
        logic             loadc;
        logic             loads;
        logic             asel;
        logic             bsel;
        logic [1:0]       vsel;
        logic [1:0]       alu_op;
        logic [1:0]       shift;
    } ctrl_t;

    // Idle bundle: only the ready flag is high.
    localparam ctrl_t CTRL_IDLE = '{w: 1'b1, default: '0};

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decode: field extraction, sign extension and
// classification of the IR into a legal instruction kind or illegal.
module instr_decode
    import sm_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] ir_i,
    output instr_e           kind_o,
    output logic [1:0]       op_o,
    output logic [IDX_W-1:0] rn_o,
    output logic [IDX_W-1:0] rd_o,
    output logic [1:0]       sh_o,
    output logic [IDX_W-1:0] rm_o,
    output logic [WIDTH-1:0] sximm8_o,
    output logic [WIDTH-1:0] sximm5_o
);

    logic [2:0] opcode;

    assign opcode   = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm8_o = {{(WIDTH-8){ir_i[7]}}, ir_i[7:0]};
    assign sximm5_o = {{(WIDTH-5){ir_i[4]}}, ir_i[4:0]};

    // Anything outside the MOV and ALU groups falls through to illegal.
    always_comb begin
        kind_o = INS_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op_o == OP_MOV_IMM) begin
                kind_o = INS_MOV_IMM;
            end else if (op_o == OP_MOV_REG) begin
                kind_o = INS_MOV_REG;
            end
        end else if (opcode == OPC_ALU) begin
            case (op_o)
                ALU_ADD: kind_o = INS_ADD;
                ALU_SUB: kind_o = INS_CMP;
                ALU_AND: kind_o = INS_AND;
                default: kind_o = INS_MVN;
            endcase
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle controller in front of the ALU: holds the IR, walks the
// register-read / execute / write-back sequence, and reports idle on w.
module instruction_sequencer
    import sm_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             s,
    output logic             w,
    output logic             err,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic [1:0]       ALUop,
    output logic [1:0]       shift,
    output logic [WIDTH-1:0] sximm8,
    output logic [WIDTH-1:0] sximm5
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    ctrl_t            ctrl_q, ctrl_d;

    instr_e           kind;
    logic [1:0]       op;
    logic [IDX_W-1:0] rn, rd, rm;
    logic [1:0]       sh;

    instr_decode #(.WIDTH(WIDTH)) u_decode (
        .ir_i     (ir_q),
        .kind_o   (kind),
        .op_o     (op),
        .rn_o     (rn),
        .rd_o     (rd),
        .sh_o     (sh),
        .rm_o     (rm),
        .sximm8_o (sximm8),
        .sximm5_o (sximm5)
    );

    // Next state and IR capture; load has priority over s while idle.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (load) begin
                    ir_d = in;
                end else if (s) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (kind)
                    INS_MOV_IMM:                 state_d = S_WRITE_IMM;
                    INS_MOV_REG, INS_MVN:        state_d = S_GET_B;
                    INS_ADD, INS_CMP, INS_AND:   state_d = S_GET_A;
                    default:                     state_d = S_WAIT;
                endcase
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_EXEC;
            S_EXEC:      state_d = (kind == INS_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Controls are decoded from the upcoming state so they register in step
    // with it; the IR cannot change once the sequence has left WAIT.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_WAIT:   ctrl_d.w   = 1'b1;
            S_DECODE: ctrl_d.err = (kind == INS_ILLEGAL);
            S_WRITE_IMM: begin
                ctrl_d.writenum = rn;
                ctrl_d.vsel     = VSEL_IMM8;
                ctrl_d.write    = 1'b1;
            end
            S_GET_A: begin
                ctrl_d.readnum = rn;
                ctrl_d.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl_d.readnum = rm;
                ctrl_d.loadb   = 1'b1;
            end
            S_EXEC: begin
                ctrl_d.shift = sh;
                ctrl_d.loadc = 1'b1;
                if (kind == INS_MOV_REG) begin
                    ctrl_d.alu_op = ALU_ADD;
                    ctrl_d.asel   = 1'b1;
                end else begin
                    ctrl_d.alu_op = op;
                    ctrl_d.loads  = 1'b1;
                end
            end
            S_WRITE_REG: begin
                ctrl_d.writenum = rd;
                ctrl_d.vsel     = VSEL_C;
                ctrl_d.write    = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign w        = ctrl_q.w;
    assign err      = ctrl_q.err;
    assign readnum  = ctrl_q.readnum;
    assign writenum = ctrl_q.writenum;
    assign write    = ctrl_q.write;
    assign loada    = ctrl_q.loada;
    assign loadb    = ctrl_q.loadb;
    assign loadc    = ctrl_q.loadc;
    assign loads    = ctrl_q.loads;
    assign asel     = ctrl_q.asel;
    assign bsel     = ctrl_q.bsel;
    assign vsel     = ctrl_q.vsel;
    assign ALUop    = ctrl_q.alu_op;
    assign shift    = ctrl_q.shift;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: per-instruction vector table plus
// hand-written sequences for reset abort, busy loads and back-to-back starts.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic [15:0] in;
    logic        s;
    logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, ALUop, shift;
    logic [15:0] sximm8, sximm5;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .in       (in),
        .s        (s),
        .w        (w),
        .err      (err),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .ALUop    (ALUop),
        .shift    (shift),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] instr;
        int          lat;
        int          nwr;
        int          wnum;
        int          vs;
        int          nla;
        int          ra;
        int          nlb;
        int          rb;
        int          nlc;
        int          aluop;
        int          nls;
        int          nasel;
        int          sh;
        int          nerr;
        logic [15:0] sx8;
        logic [15:0] sx5;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] ctl_bits();
        return {err, readnum, writenum, write, loada, loadb, loadc, loads,
                asel, bsel, vsel, ALUop, shift};
    endfunction

    // Load the IR in one cycle, then assert s for the accept edge.
    task automatic start(input logic [15:0] instr);
        load = 1'b1;
        in   = instr;
        tick();
        load = 1'b0;
        s    = 1'b1;
        tick();
        s    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc = 0;
        int nwr = 0, nla = 0, nlb = 0, nlc = 0, nls = 0, nasel = 0, nerr = 0, nbsel = 0;
        int wnum = 0, vs = 0, ra = 0, rb = 0, aluop = 0, sh = 0;
        start(v.instr);
        while (!w && cyc < 12) begin
            if (write) begin nwr++; wnum = int'(writenum); vs = int'(vsel); end
            if (loada) begin nla++; ra = int'(readnum); end
            if (loadb) begin nlb++; rb = int'(readnum); end
            if (loadc) begin nlc++; aluop = int'(ALUop); sh = int'(shift); end
            if (loads) nls++;
            if (asel)  nasel++;
            if (bsel)  nbsel++;
            if (err)   nerr++;
            tick();
            cyc++;
        end
        check({v.name, ".lat"},   32'(cyc),   32'(v.lat));
        check({v.name, ".nwr"},   32'(nwr),   32'(v.nwr));
        check({v.name, ".wnum"},  32'(wnum),  32'(v.wnum));
        check({v.name, ".vsel"},  32'(vs),    32'(v.vs));
        check({v.name, ".nla"},   32'(nla),   32'(v.nla));
        check({v.name, ".ra"},    32'(ra),    32'(v.ra));
        check({v.name, ".nlb"},   32'(nlb),   32'(v.nlb));
        check({v.name, ".rb"},    32'(rb),    32'(v.rb));
        check({v.name, ".nlc"},   32'(nlc),   32'(v.nlc));
        check({v.name, ".aluop"}, 32'(aluop), 32'(v.aluop));
        check({v.name, ".nls"},   32'(nls),   32'(v.nls));
        check({v.name, ".nasel"}, 32'(nasel), 32'(v.nasel));
        check({v.name, ".nbsel"}, 32'(nbsel), 32'h0);
        check({v.name, ".shift"}, 32'(sh),    32'(v.sh));
        check({v.name, ".nerr"},  32'(nerr),  32'(v.nerr));
        check({v.name, ".sx8"},   32'(sximm8), 32'(v.sx8));
        check({v.name, ".sx5"},   32'(sximm5), 32'(v.sx5));
    endtask

    initial begin
        int nwr;

        //        name     instr     lat nwr wn vs nla ra nlb rb nlc op nls nas sh nerr sx8       sx5
        vecs[0]  = '{"movi7",  16'hD207, 2, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0007, 16'h0007};
        vecs[1]  = '{"movim1", 16'hD0FF, 2, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF};
        vecs[2]  = '{"movr",   16'hC0AB, 4, 1, 5, 0, 0, 0, 1, 3, 1, 0, 0, 1, 1, 0, 16'hFFAB, 16'h000B};
        vecs[3]  = '{"mvn",    16'hB834, 4, 1, 1, 0, 0, 0, 1, 4, 1, 3, 1, 0, 2, 0, 16'h0034, 16'hFFF4};
        vecs[4]  = '{"add",    16'hA162, 5, 1, 3, 0, 1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 16'h0062, 16'h0002};
        vecs[5]  = '{"and",    16'hB4FE, 5, 1, 7, 0, 1, 4, 1, 6, 1, 2, 1, 0, 3, 0, 16'hFFFE, 16'hFFFE};
        vecs[6]  = '{"cmp",    16'hA901, 4, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 16'h0001, 16'h0001};
        vecs[7]  = '{"ill0",   16'hE000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000};
        vecs[8]  = '{"ill1",   16'hC800, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000};
        vecs[9]  = '{"ill2",   16'h1F3C, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h003C, 16'hFFFC};
        vecs[10] = '{"ill3",   16'hDFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 16'hFFFF};

        reset_n = 1'b0;
        load    = 1'b0;
        s       = 1'b0;
        in      = 16'h0000;
        #12;
        check("rst.w",    32'(w), 32'h1);
        check("rst.ctl",  32'(ctl_bits()), 32'h0);
        check("rst.sx8",  32'(sximm8), 32'h0);
        reset_n = 1'b1;
        tick();

        // MOV R2,#7 cycle by cycle
        start(16'hD207);
        check("movi.dec.w",     32'(w), 32'h0);
        check("movi.dec.ctl",   32'(ctl_bits()), 32'h0);
        tick();
        check("movi.wr.write",  32'(write), 32'h1);
        check("movi.wr.wnum",   32'(writenum), 32'h2);
        check("movi.wr.vsel",   32'(vsel), 32'h2);
        check("movi.wr.sx8",    32'(sximm8), 32'h0007);
        check("movi.wr.w",      32'(w), 32'h0);
        tick();
        check("movi.done.w",    32'(w), 32'h1);
        check("movi.done.wr",   32'(write), 32'h0);

        // ADD ordering, then reset during GET_B
        start(16'hA162);
        tick();
        check("add.ga.readnum", 32'(readnum), 32'h1);
        check("add.ga.loada",   32'(loada), 32'h1);
        check("add.ga.loadb",   32'(loadb), 32'h0);
        tick();
        check("add.gb.readnum", 32'(readnum), 32'h2);
        check("add.gb.loadb",   32'(loadb), 32'h1);
        check("add.gb.loada",   32'(loada), 32'h0);
        reset_n = 1'b0;
        #1;
        check("abort.w",        32'(w), 32'h1);
        check("abort.ctl",      32'(ctl_bits()), 32'h0);
        #2;
        reset_n = 1'b1;
        nwr = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (write || !w) nwr++;
        end
        check("abort.idle",     32'(nwr), 32'h0);
        check("abort.ir.sx8",   32'(sximm8), 32'h0);
        check("abort.ir.sx5",   32'(sximm5), 32'h0);

        // Load pulsed during EXEC must not disturb the IR
        start(16'hA162);
        tick();
        tick();
        tick();
        check("busy.ex.loadc",  32'(loadc), 32'h1);
        check("busy.ex.loads",  32'(loads), 32'h1);
        check("busy.ex.aluop",  32'(ALUop), 32'h0);
        check("busy.ex.asel",   32'(asel), 32'h0);
        load = 1'b1;
        in   = 16'hD0FF;
        tick();
        load = 1'b0;
        check("busy.wr.write",  32'(write), 32'h1);
        check("busy.wr.wnum",   32'(writenum), 32'h3);
        check("busy.wr.vsel",   32'(vsel), 32'h0);
        check("busy.wr.sx8",    32'(sximm8), 32'h0062);
        tick();
        check("busy.done.w",    32'(w), 32'h1);
        check("busy.done.sx8",  32'(sximm8), 32'h0062);

        // load and s together: load wins, s starts on the following cycle
        load = 1'b1;
        s    = 1'b1;
        in   = 16'hD207;
        tick();
        load = 1'b0;
        check("ls.w",           32'(w), 32'h1);
        check("ls.sx8",         32'(sximm8), 32'h0007);
        tick();
        check("ls.dec.w",       32'(w), 32'h0);
        tick();
        check("b2b.wr.write",   32'(write), 32'h1);
        tick();
        check("b2b.wait.w",     32'(w), 32'h1);
        tick();
        check("b2b.dec.w",      32'(w), 32'h0);
        s = 1'b0;
        tick();
        check("b2b.wr2.write",  32'(write), 32'h1);
        tick();
        check("b2b.end.w",      32'(w), 32'h1);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Multi-cycle controller sitting directly upstream of the 16-bit ALU in the simple RISC datapath.
- Holds the current instruction in an instruction register (IR) and decodes it.
- Sequences register-file reads into operand registers A and B, drives ALUop and shift, then captures the ALU result and status and writes the result back.
- Completion is reported to the host through a start/wait handshake (s / w).

Parameters:
- WIDTH, 16, datapath and instruction width; sign-extension target width for sximm8 and sximm5.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  capture `in` into IR
- in  in  16  instruction word
- s  in  1  start execution of the instruction held in IR (level-sampled)
- w  out  1  idle/ready; 1 only in state WAIT
- err  out  1  one-cycle pulse on an illegal opcode
- readnum  out  3  register-file read index
- writenum  out  3  register-file write index
- write  out  1  register-file write enable
- loada, loadb  out  1  each  load enables for operand registers A and B
- loadc  out  1  load enable for the result register C
- loads  out  1  load enable for the status register (captures ALU status[2:0])
- asel  out  1  1 = force ALU Ain to 0
- bsel  out  1  1 = ALU Bin from sximm5
- vsel  out  2  write-back source: 00 = C, 10 = sximm8; 01 and 11 are never driven
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
- shift  out  2  shifter control applied to B
- sximm8  out  16  sign-extended IR[7:0]
- sximm5  out  16  sign-extended IR[4:0]

Behaviour:
- IR fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Decoded instruction set:
  - 110/10 = MOV Rn,#imm8
  - 110/00 = MOV Rd,Rm{,sh}
  - 101/00 = ADD
  - 101/01 = CMP
  - 101/10 = AND
  - 101/11 = MVN
  - Every other opcode/op combination is illegal.
- Reset (async, reset_n=0):
  - State = WAIT, IR = 0.
  - w = 1; err = 0; all enables, selects, indices and ALUop/shift = 0.
  - Asserting reset mid-instruction aborts it; no write occurs after reset assertion.
- IR loading:
  - IR <= in on a clock edge with load=1 and state WAIT.
  - load is ignored in any other state.
  - If load and s are both high in WAIT, the instruction is loaded and s is ignored that cycle; execution starts on the next cycle that s is high.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG.
- Transitions (one state per cycle):
  - WAIT -> DECODE when s=1 and load=0.
  - DECODE -> WRITE_IMM for MOV-imm.
  - DECODE -> GET_B for MOV-reg and MVN.
  - DECODE -> GET_A for ADD, CMP and AND.
  - DECODE -> WAIT for illegal, with err=1 for that cycle.
  - WRITE_IMM -> WAIT.
  - GET_A -> GET_B -> EXEC.
  - EXEC -> WRITE_REG for all instructions except CMP; CMP goes EXEC -> WAIT.
  - WRITE_REG -> WAIT.
- Outputs per state (all unlisted controls 0):
  - WRITE_IMM: writenum=Rn, vsel=10, write=1.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - EXEC: shift=sh, loadc=1, bsel=0.
    - ALUop = op for opcode 101; ALUop = 00 with asel=1 for MOV-reg.
    - loads=1 for opcode 101 only.
  - WRITE_REG: writenum=Rd, vsel=00, write=1.
- Latency, counted in cycles from the s-accept edge back to w=1:
  - MOV-imm 2; MOV-reg 4; MVN 4; ADD and AND 5; CMP 4; illegal 1.
- Back-to-back: if s is still high on the first WAIT cycle, the next instruction starts immediately; w is high for exactly that one cycle.
- sximm8 and sximm5 are combinational from IR; they are valid in every state.
- Outputs are Moore-style from state and IR. No output depends combinationally on s or load, except that w is purely state-derived.

Decomposition:
- Shared package sm_pkg holds:
  - opcode/op constants (OPC_MOV=110, OPC_ALU=101, ALU_ADD/SUB/AND/NOTB);
  - state enum encoding;
  - vsel codes VSEL_C=00, VSEL_IMM8=10.
- One combinational sub-module, instr_decode: field extraction, sign extension and legality check. The FSM and IR stay in instruction_sequencer.

Test Plan:
- MOV-imm:
  - Stimulus: reset; load in=16'hD207 (MOV R2,#7); s=1.
  - Required: next cycle DECODE; following cycle write=1, writenum=2, vsel=10, sximm8=16'h0007; w=1 two cycles after accept.
- Negative immediate:
  - Stimulus: in=16'hD0FF (MOV R0,#-1).
  - Required: sximm8=16'hFFFF in the write cycle.
- ADD:
  - Stimulus: in=16'hA162 (ADD R3,R1,R2).
  - Required, in order: readnum=1 with loada=1; then readnum=2 with loadb=1; then ALUop=00, loadc=1, loads=1, asel=0; then writenum=3, write=1, vsel=00; w high 5 cycles after accept.
- CMP:
  - Stimulus: in=16'hA901 (CMP R1,R1).
  - Required: EXEC shows ALUop=01, loads=1; no write pulse occurs at any time; back in WAIT after 4 cycles.
- Illegal opcode:
  - Stimulus: in=16'hE000.
  - Required: err=1 for exactly one cycle in DECODE, write never asserted, w=1 on the next cycle.
- Reset mid-instruction:
  - Stimulus: start ADD, drop reset_n during GET_B.
  - Required: immediately w=1, all controls 0; IR reads 0 after release.
- Load while busy:
  - Stimulus: pulse load during EXEC.
  - Required: IR unchanged.
